fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding and address-space sizing.
// The ROM depth is derived from DATA_SIZE, the existing top ROM word index.
`ifndef DATA_SIZE
`define DATA_SIZE 65535
`endif

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fs_state_t;

  localparam int          ADDR_W_DEFAULT    = 16;
  localparam int unsigned MEM_DEPTH_DEFAULT = (`DATA_SIZE) + 1;

endpackage

// File: rtl/fetch_sequencer.sv
// PC / fetch-control stage feeding a registered instruction ROM; tracks which
// address the ROM output holds and presents it to decode with a valid flag.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic [15:0]       fetch_count,
    output logic              addr_fault,
    output logic              halted,
    output fs_state_t         state_dbg
);

    // Handshake: decode accepts the word on the ROM output in any RUN cycle
    // where if_valid=1 and stall=0; otherwise the same word is re-read.

    fs_state_t         state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              take_addr;
    logic              halt_take;
    logic              addr_oob;

    always_comb begin
        imem_addr = if_pc;
        take_addr = 1'b0;
        halt_take = 1'b0;
        if (reset) begin
            imem_addr = '0;
        end else begin
            case (state)
                BOOT: imem_addr = '0;
                RUN: begin
                    if (halt && !stall) begin
                        halt_take = 1'b1;
                        imem_addr = if_pc;
                    end else if (redirect_valid) begin
                        imem_addr = redirect_target;
                        take_addr = 1'b1;
                    end else if (stall) begin
                        imem_addr = if_pc;
                    end else begin
                        imem_addr = fetch_pc;
                        take_addr = 1'b1;
                    end
                end
                default: imem_addr = if_pc;
            endcase
        end
    end

    // The offending address is still driven for the faulting cycle.
    assign addr_oob = 32'(imem_addr) >= MEM_DEPTH;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= ADDR_W'(1);
            if_pc       <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
            addr_fault  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    if_valid <= 1'b1;
                    if_pc    <= '0;
                    fetch_pc <= ADDR_W'(1);
                end
                RUN: begin
                    if (if_valid && !stall && fetch_count != 16'hFFFF)
                        fetch_count <= fetch_count + 16'd1;
                    if (halt_take) begin
                        state    <= HALTED;
                        if_valid <= 1'b0;
                    end else if (take_addr) begin
                        if (addr_oob) begin
                            addr_fault <= 1'b1;
                            state      <= HALTED;
                            if_valid   <= 1'b0;
                        end else begin
                            if_pc    <= imem_addr;
                            fetch_pc <= imem_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= HALTED;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

    assign halted    = (state == HALTED);
    assign state_dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a full-depth instance for boot/stall/redirect/
// halt/wrap/saturation and a 16-word instance for fault behaviour.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int EW = 51;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_f;
    logic        stall;
    logic        rv;
    logic [15:0] rt;
    logic        halt;

    logic [15:0] m_addr, m_pc, m_cnt;
    logic        m_valid, m_fault, m_halted;
    fs_state_t   m_state;
    logic [15:0] f_addr, f_pc, f_cnt;
    logic        f_valid, f_fault, f_halted;
    fs_state_t   f_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_f_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    fetch_sequencer dut (
        .clk(clk), .reset(rst), .stall(stall), .redirect_valid(rv),
        .redirect_target(rt), .halt(halt), .imem_addr(m_addr), .if_pc(m_pc),
        .if_valid(m_valid), .fetch_count(m_cnt), .addr_fault(m_fault),
        .halted(m_halted), .state_dbg(m_state)
    );

    fetch_sequencer #(.ADDR_W(16), .MEM_DEPTH(16)) dut_f (
        .clk(clk), .reset(rst_f), .stall(stall), .redirect_valid(rv),
        .redirect_target(rt), .halt(halt), .imem_addr(f_addr), .if_pc(f_pc),
        .if_valid(f_valid), .fetch_count(f_cnt), .addr_fault(f_fault),
        .halted(f_halted), .state_dbg(f_state)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack(input logic [15:0] ea, input logic [15:0] ep,
                                           input logic ev, input logic [15:0] ec,
                                           input logic ef, input logic eh);
        return {ea, ep, ev, ec, ef, eh};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [EW-1:0] e,
                           input logic [15:0] a, input logic [15:0] p, input logic v,
                           input logic [15:0] c, input logic f, input logic h);
        chk({tag, ".imem_addr"},   a,       e[50:35]);
        chk({tag, ".if_pc"},       p,       e[34:19]);
        chk({tag, ".if_valid"},    16'(v),  16'(e[18]));
        chk({tag, ".fetch_count"}, c,       e[17:2]);
        chk({tag, ".addr_fault"},  16'(f),  16'(e[1]));
        chk({tag, ".halted"},      16'(h),  16'(e[0]));
    endtask

    // Monitor: compares on the falling edge, between driver updates.
    always @(negedge clk) begin
        if (exp_q.size() > 0)
            chk_all("main", exp_q.pop_front(), m_addr, m_pc, m_valid, m_cnt, m_fault, m_halted);
        if (exp_f_q.size() > 0)
            chk_all("small", exp_f_q.pop_front(), f_addr, f_pc, f_valid, f_cnt, f_fault, f_halted);
    end

    task automatic mv(input logic r, input logic s, input logic v, input logic [15:0] t,
                      input logic h, input logic [15:0] ea, input logic [15:0] ep,
                      input logic ev, input logic [15:0] ec, input logic ef, input logic eh);
        rst = r; rst_f = 1'b1; stall = s; rv = v; rt = t; halt = h;
        exp_q.push_back(pack(ea, ep, ev, ec, ef, eh));
        @(posedge clk); #1;
    endtask

    task automatic fv(input logic r, input logic s, input logic v, input logic [15:0] t,
                      input logic h, input logic [15:0] ea, input logic [15:0] ep,
                      input logic ev, input logic [15:0] ec, input logic ef, input logic eh);
        rst = 1'b1; rst_f = r; stall = s; rv = v; rt = t; halt = h;
        exp_f_q.push_back(pack(ea, ep, ev, ec, ef, eh));
        @(posedge clk); #1;
    endtask

    task automatic free_run(input int n);
        rst = 1'b0; rst_f = 1'b1; stall = 1'b0; rv = 1'b0; rt = '0; halt = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst_f = 1'b1; stall = 1'b0; rv = 1'b0; rt = '0; halt = 1'b0;
        @(posedge clk); #1;
        // reset held, then boot and sequential fetch
        mv(1,0,0,16'h0000,0, 16'h0000,16'h0000,0,16'd0,0,0);
        mv(1,0,0,16'h0000,0, 16'h0000,16'h0000,0,16'd0,0,0);
        mv(0,0,0,16'h0000,0, 16'h0000,16'h0000,0,16'd0,0,0);
        mv(0,0,0,16'h0000,0, 16'h0001,16'h0000,1,16'd0,0,0);
        mv(0,0,0,16'h0000,0, 16'h0002,16'h0001,1,16'd1,0,0);
        mv(0,0,0,16'h0000,0, 16'h0003,16'h0002,1,16'd2,0,0);
        mv(0,0,0,16'h0000,0, 16'h0004,16'h0003,1,16'd3,0,0);
        mv(0,0,0,16'h0000,0, 16'h0005,16'h0004,1,16'd4,0,0);
        // three stall cycles at if_pc=5
        mv(0,1,0,16'h0000,0, 16'h0005,16'h0005,1,16'd5,0,0);
        mv(0,1,0,16'h0000,0, 16'h0005,16'h0005,1,16'd5,0,0);
        mv(0,1,0,16'h0000,0, 16'h0005,16'h0005,1,16'd5,0,0);
        mv(0,0,0,16'h0000,0, 16'h0006,16'h0005,1,16'd5,0,0);
        mv(0,0,0,16'h0000,0, 16'h0007,16'h0006,1,16'd6,0,0);
        // redirect overrides stall
        mv(0,1,1,16'h0040,0, 16'h0040,16'h0007,1,16'd7,0,0);
        mv(0,0,0,16'h0000,0, 16'h0041,16'h0040,1,16'd7,0,0);
        mv(0,0,0,16'h0000,0, 16'h0042,16'h0041,1,16'd8,0,0);
        // halt at if_pc=9; later redirects ignored
        mv(0,0,1,16'h0009,0, 16'h0009,16'h0042,1,16'd9,0,0);
        mv(0,0,0,16'h0000,1, 16'h0009,16'h0009,1,16'd10,0,0);
        mv(0,0,1,16'h0020,0, 16'h0009,16'h0009,0,16'd11,0,1);
        mv(0,0,0,16'h0000,0, 16'h0009,16'h0009,0,16'd11,0,1);
        // reset forces imem_addr=0 immediately; BOOT ignores all inputs
        mv(1,0,0,16'h0000,0, 16'h0000,16'h0009,0,16'd11,0,1);
        mv(0,1,1,16'h0030,1, 16'h0000,16'h0000,0,16'd0,0,0);
        mv(0,0,0,16'h0000,0, 16'h0001,16'h0000,1,16'd0,0,0);
        // halt with stall behaves as a stall
        mv(0,1,0,16'h0000,1, 16'h0001,16'h0001,1,16'd1,0,0);
        mv(0,0,0,16'h0000,0, 16'h0002,16'h0001,1,16'd1,0,0);
        // wrap 0xFFFF -> 0x0000 without fault
        mv(0,0,1,16'hFFFF,0, 16'hFFFF,16'h0002,1,16'd2,0,0);
        mv(0,0,0,16'h0000,0, 16'h0000,16'hFFFF,1,16'd3,0,0);
        mv(0,0,0,16'h0000,0, 16'h0001,16'h0000,1,16'd4,0,0);
        // long run up to the saturation point
        free_run(65528);
        mv(0,0,0,16'h0000,0, 16'hFFFA,16'hFFF9,1,16'hFFFD,0,0);
        mv(0,0,0,16'h0000,0, 16'hFFFB,16'hFFFA,1,16'hFFFE,0,0);
        mv(0,0,0,16'h0000,0, 16'hFFFC,16'hFFFB,1,16'hFFFF,0,0);
        mv(0,0,0,16'h0000,0, 16'hFFFD,16'hFFFC,1,16'hFFFF,0,0);
        // 16-word instance: redirect fault
        fv(0,0,0,16'h0000,0, 16'h0000,16'h0000,0,16'd0,0,0);
        fv(0,0,0,16'h0000,0, 16'h0001,16'h0000,1,16'd0,0,0);
        fv(0,0,1,16'h0010,0, 16'h0010,16'h0001,1,16'd1,0,0);
        fv(0,0,0,16'h0000,0, 16'h0001,16'h0001,0,16'd2,1,1);
        fv(0,0,1,16'h0003,0, 16'h0001,16'h0001,0,16'd2,1,1);
        // sequential fault crossing 15 -> 16
        fv(1,0,0,16'h0000,0, 16'h0000,16'h0001,0,16'd2,1,1);
        fv(0,0,0,16'h0000,0, 16'h0000,16'h0000,0,16'd0,0,0);
        fv(0,0,1,16'h000F,0, 16'h000F,16'h0000,1,16'd0,0,0);
        fv(0,0,0,16'h0000,0, 16'h0010,16'h000F,1,16'd1,0,0);
        fv(0,0,0,16'h0000,0, 16'h000F,16'h000F,0,16'd2,1,1);

        for (int i = 0; i < 4 && (exp_q.size() + exp_f_q.size()) > 0; i++)
            @(posedge clk);
        if ((exp_q.size() + exp_f_q.size()) > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size() + exp_f_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
